// File: rtl/ram_io_responder.sv
// rtl/ram_io_responder.sv - byte-wide RAM bus responder with UART-style IO window
//
// Purpose:
//   Serves byte reads/writes from the memory controller to on-chip block RAM.
//   Bus address bit 17 selects a small IO window instead of RAM:
//     0x30000  UART data: write pushes TX FIFO, read returns RX head (pop on run start)
//     0x30004  status   : {6'b0, rx_nonempty, tx_full}
//     0x30008  halt     : any write sets the sticky halt flag
//   Other IO addresses ignore writes and read as 8'h00.
//   The CPU is stalled through cpu_rdy whenever the TX FIFO is full.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   bus_a, bus_wr, bus_wdata      controller address / write strobe / write byte
//   bus_rdata                     registered read byte (one cycle after address)
//   cpu_rdy                       0 = bus inputs ignored this cycle
//   tx_data, tx_valid, tx_ready   host-side TX FIFO drain (first-word-fall-through)
//   rx_data, rx_valid, rx_ready   host-side RX FIFO fill
//   halt                          sticky halt request

module ram_io_responder #(
  parameter int RAM_AW  = 17,
  parameter int FIFO_AW = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] bus_a,
  input  logic        bus_wr,
  input  logic [7:0]  bus_wdata,
  output logic [7:0]  bus_rdata,
  output logic        cpu_rdy,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        halt
);

  localparam int                 DEPTH     = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]   FIFO_FULL = (FIFO_AW + 1)'(DEPTH);
  localparam logic [17:0]        A_UART    = 18'h30000;
  localparam logic [17:0]        A_STAT    = 18'h30004;
  localparam logic [17:0]        A_HALT    = 18'h30008;

  // Only the low 18 address bits are decoded.
  logic unused_bus_a;
  assign unused_bus_a = ^bus_a[31:18];

  logic [7:0]          ram_q [2**RAM_AW];
  logic [RAM_AW-1:0]   ram_idx;
  logic                io_sel;

  logic [7:0]          tx_mem_q [DEPTH];
  logic [FIFO_AW-1:0]  tx_wr_q, tx_rd_q;
  logic [FIFO_AW:0]    tx_count_q, tx_count_d;
  logic                tx_full, tx_push, tx_pop;

  logic [7:0]          rx_mem_q [DEPTH];
  logic [FIFO_AW-1:0]  rx_wr_q, rx_rd_q;
  logic [FIFO_AW:0]    rx_count_q, rx_count_d;
  logic                rx_full, rx_nonempty, rx_push, rx_pop;

  logic                rd_rx, rd_rx_q;
  logic [7:0]          bus_rdata_q, bus_rdata_d, io_rdata;
  logic                halt_q, halt_d;
  logic                bus_rd, bus_we;

  assign ram_idx = bus_a[RAM_AW-1:0];
  assign io_sel  = bus_a[17];

  assign tx_full     = (tx_count_q == FIFO_FULL);
  assign rx_full     = (rx_count_q == FIFO_FULL);
  assign rx_nonempty = (rx_count_q != '0);

  assign cpu_rdy  = ~tx_full;
  assign tx_valid = (tx_count_q != '0);
  assign tx_data  = tx_mem_q[tx_rd_q];
  assign rx_ready = ~rx_full;
  assign halt     = halt_q;
  assign bus_rdata = bus_rdata_q;

  // Bus operations only take effect on cycles the CPU is allowed to advance.
  assign bus_we = cpu_rdy & bus_wr;
  assign bus_rd = cpu_rdy & ~bus_wr;

  // rd_rx is the raw "controller is presenting a UART data read" condition; the
  // pop fires only on the first cycle of a run so a held address pops once.
  assign rd_rx   = ~bus_wr & (bus_a[17:0] == A_UART);
  assign rx_pop  = cpu_rdy & rd_rx & ~rd_rx_q & rx_nonempty;
  assign rx_push = rx_valid & ~rx_full;

  assign tx_push = bus_we & (bus_a[17:0] == A_UART);
  assign tx_pop  = tx_ready & tx_valid;

  always_comb begin
    tx_count_d = tx_count_q;
    case ({tx_push, tx_pop})
      2'b10:   tx_count_d = tx_count_q + 1'b1;
      2'b01:   tx_count_d = tx_count_q - 1'b1;
      default: tx_count_d = tx_count_q;
    endcase
  end

  always_comb begin
    rx_count_d = rx_count_q;
    case ({rx_push, rx_pop})
      2'b10:   rx_count_d = rx_count_q + 1'b1;
      2'b01:   rx_count_d = rx_count_q - 1'b1;
      default: rx_count_d = rx_count_q;
    endcase
  end

  always_comb begin
    io_rdata = 8'h00;
    case (bus_a[17:0])
      A_UART:  io_rdata = rx_nonempty ? rx_mem_q[rx_rd_q] : 8'h00;
      A_STAT:  io_rdata = {6'b0, rx_nonempty, tx_full};
      default: io_rdata = 8'h00;
    endcase
  end

  always_comb begin
    halt_d = halt_q;
    if (bus_we && bus_a[17:0] == A_HALT) halt_d = 1'b1;
  end

  // RAM is not reset; writes are dropped while rst is high so a reset cycle
  // never leaves a partial effect behind.
  always_ff @(posedge clk) begin
    if (!rst && bus_we && !io_sel) ram_q[ram_idx] <= bus_wdata;
  end

  always_comb begin
    bus_rdata_d = bus_rdata_q;
    if (bus_rd) bus_rdata_d = io_sel ? io_rdata : ram_q[ram_idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_rdata_q <= 8'h00;
      halt_q      <= 1'b0;
      rd_rx_q     <= 1'b0;
    end else begin
      bus_rdata_q <= bus_rdata_d;
      halt_q      <= halt_d;
      // A stalled cycle does not end or start a run of UART reads.
      if (cpu_rdy) rd_rx_q <= rd_rx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wr_q    <= '0;
      tx_rd_q    <= '0;
      tx_count_q <= '0;
      rx_wr_q    <= '0;
      rx_rd_q    <= '0;
      rx_count_q <= '0;
    end else begin
      if (tx_push) begin
        tx_mem_q[tx_wr_q] <= bus_wdata;
        tx_wr_q           <= tx_wr_q + 1'b1;
      end
      if (tx_pop) tx_rd_q <= tx_rd_q + 1'b1;
      tx_count_q <= tx_count_d;

      if (rx_push) begin
        rx_mem_q[rx_wr_q] <= rx_data;
        rx_wr_q           <= rx_wr_q + 1'b1;
      end
      if (rx_pop) rx_rd_q <= rx_rd_q + 1'b1;
      rx_count_q <= rx_count_d;
    end
  end

endmodule

// File: tb/tb_ram_io_responder.sv
// tb/tb_ram_io_responder.sv - directed self-checking bench for ram_io_responder

module tb_ram_io_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] bus_a;
  logic        bus_wr;
  logic [7:0]  bus_wdata;
  logic [7:0]  bus_rdata;
  logic        cpu_rdy;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        halt;

  int total = 0;
  int bad   = 0;

  ram_io_responder dut (
    .clk(clk), .rst(rst),
    .bus_a(bus_a), .bus_wr(bus_wr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .cpu_rdy(cpu_rdy),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .halt(halt)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic bus_set(input logic [31:0] a, input logic wr, input logic [7:0] wd);
    bus_a = a; bus_wr = wr; bus_wdata = wd;
  endtask

  task automatic test_reset;
    rst = 1'b1; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    bus_set(32'h0, 1'b0, 8'h00);
    tick; tick;
    rst = 1'b0;
    total++; if (bus_rdata !== 8'h00) begin bad++; $display("FAIL reset_rdata got=%h exp=00", bus_rdata); end
    total++; if (cpu_rdy !== 1'b1) begin bad++; $display("FAIL reset_cpu_rdy got=%b exp=1", cpu_rdy); end
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); end
    total++; if (rx_ready !== 1'b1) begin bad++; $display("FAIL reset_rx_ready got=%b exp=1", rx_ready); end
    total++; if (halt !== 1'b0) begin bad++; $display("FAIL reset_halt got=%b exp=0", halt); end
  endtask

  task automatic test_write_read;
    bus_set(32'h10, 1'b1, 8'hA5); tick;
    bus_set(32'h10, 1'b0, 8'h00); tick;
    total++; if (bus_rdata !== 8'hA5) begin bad++; $display("FAIL wr_rd_0x10 got=%h exp=a5", bus_rdata); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp [4];
    exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h33; exp[3] = 8'h44;
    for (int i = 0; i < 4; i++) begin
      bus_set(32'h100 + 32'(i), 1'b1, exp[i]); tick;
      total++; if (bus_rdata !== 8'hA5) begin bad++; $display("FAIL rdata_hold_on_write i=%0d got=%h exp=a5", i, bus_rdata); end
    end
    for (int i = 0; i < 4; i++) begin
      bus_set(32'h100 + 32'(i), 1'b0, 8'h00); tick;
      total++; if (bus_rdata !== exp[i]) begin bad++; $display("FAIL burst_rd i=%0d got=%h exp=%h", i, bus_rdata, exp[i]); end
    end
  endtask

  task automatic test_tx_full;
    bus_set(32'h20, 1'b1, 8'h12); tick;
    tx_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      total++; if (cpu_rdy !== 1'b1) begin bad++; $display("FAIL tx_fill_rdy i=%0d got=%b exp=1", i, cpu_rdy); end
      bus_set(32'h30000, 1'b1, 8'hC0 + 8'(i)); tick;
    end
    total++; if (cpu_rdy !== 1'b0) begin bad++; $display("FAIL tx_full_rdy got=%b exp=0", cpu_rdy); end
    total++; if (tx_data !== 8'hC0) begin bad++; $display("FAIL tx_head got=%h exp=c0", tx_data); end
    bus_set(32'h30000, 1'b1, 8'hFF); tick;
    bus_set(32'h20, 1'b1, 8'h77); tick;
    bus_set(32'h10, 1'b0, 8'h00); tick;
    total++; if (bus_rdata !== 8'h44) begin bad++; $display("FAIL stall_rdata_hold got=%h exp=44", bus_rdata); end
    total++; if (cpu_rdy !== 1'b0) begin bad++; $display("FAIL stall_rdy got=%b exp=0", cpu_rdy); end
    tx_ready = 1'b1; tick; tx_ready = 1'b0;
    total++; if (cpu_rdy !== 1'b1) begin bad++; $display("FAIL tx_pop_rdy got=%b exp=1", cpu_rdy); end
    bus_set(32'h30004, 1'b0, 8'h00);
    for (int i = 1; i < 16; i++) begin
      total++; if (tx_data !== 8'hC0 + 8'(i)) begin bad++; $display("FAIL tx_order i=%0d got=%h exp=%h", i, tx_data, 8'hC0 + 8'(i)); end
      tx_ready = 1'b1; tick; tx_ready = 1'b0;
    end
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL tx_drained got=%b exp=0", tx_valid); end
    bus_set(32'h20, 1'b0, 8'h00); tick;
    total++; if (bus_rdata !== 8'h12) begin bad++; $display("FAIL stall_ram_wr got=%h exp=12", bus_rdata); end
  endtask

  task automatic test_rx_pop;
    bus_set(32'h10, 1'b0, 8'h00);
    rx_valid = 1'b1; rx_data = 8'h41; tick;
    rx_data = 8'h42; tick;
    rx_valid = 1'b0;
    bus_set(32'h30004, 1'b0, 8'h00); tick;
    total++; if (bus_rdata !== 8'h02) begin bad++; $display("FAIL status_rx got=%h exp=02", bus_rdata); end
    bus_set(32'h30000, 1'b0, 8'h00); tick;
    total++; if (bus_rdata !== 8'h41) begin bad++; $display("FAIL rx_rd1 got=%h exp=41", bus_rdata); end
    tick;
    total++; if (bus_rdata !== 8'h42) begin bad++; $display("FAIL rx_hold2 got=%h exp=42", bus_rdata); end
    tick;
    total++; if (bus_rdata !== 8'h42) begin bad++; $display("FAIL rx_hold3 got=%h exp=42", bus_rdata); end
    bus_set(32'h10, 1'b0, 8'h00); tick;
    bus_set(32'h30000, 1'b0, 8'h00); tick;
    total++; if (bus_rdata !== 8'h42) begin bad++; $display("FAIL rx_rd2 got=%h exp=42", bus_rdata); end
    bus_set(32'h10, 1'b0, 8'h00); tick;
    bus_set(32'h30000, 1'b0, 8'h00); tick;
    total++; if (bus_rdata !== 8'h00) begin bad++; $display("FAIL rx_two_pops got=%h exp=00", bus_rdata); end
    bus_set(32'h30004, 1'b0, 8'h00); tick;
    total++; if (bus_rdata !== 8'h00) begin bad++; $display("FAIL status_empty got=%h exp=00", bus_rdata); end
  endtask

  task automatic test_empty_and_halt;
    bus_set(32'h10, 1'b0, 8'h00); tick;
    bus_set(32'h30000, 1'b0, 8'h00); tick;
    total++; if (bus_rdata !== 8'h00) begin bad++; $display("FAIL rx_empty_rd got=%h exp=00", bus_rdata); end
    bus_set(32'h10, 1'b0, 8'h00);
    rx_valid = 1'b1; rx_data = 8'h55; tick; rx_valid = 1'b0;
    bus_set(32'h30000, 1'b0, 8'h00); tick;
    total++; if (bus_rdata !== 8'h55) begin bad++; $display("FAIL rx_ptr_after_empty got=%h exp=55", bus_rdata); end
    bus_set(32'h3000C, 1'b1, 8'hEE); tick;
    bus_set(32'h3000C, 1'b0, 8'h00); tick;
    total++; if (bus_rdata !== 8'h00) begin bad++; $display("FAIL unmapped_rd got=%h exp=00", bus_rdata); end
    total++; if (halt !== 1'b0) begin bad++; $display("FAIL halt_pre got=%b exp=0", halt); end
    bus_set(32'h30008, 1'b1, 8'h00); tick;
    total++; if (halt !== 1'b1) begin bad++; $display("FAIL halt_set got=%b exp=1", halt); end
    bus_set(32'h10, 1'b0, 8'h00); tick; tick;
    total++; if (halt !== 1'b1) begin bad++; $display("FAIL halt_sticky got=%b exp=1", halt); end
    rx_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      rx_data = 8'h60 + 8'(i); tick;
    end
    total++; if (rx_ready !== 1'b0) begin bad++; $display("FAIL rx_full_ready got=%b exp=0", rx_ready); end
    rx_data = 8'h99; tick; rx_valid = 1'b0;
    bus_set(32'h30000, 1'b0, 8'h00); tick;
    total++; if (bus_rdata !== 8'h60) begin bad++; $display("FAIL rx_full_head got=%h exp=60", bus_rdata); end
    total++; if (rx_ready !== 1'b1) begin bad++; $display("FAIL rx_ready_after_pop got=%b exp=1", rx_ready); end
  endtask

  task automatic test_reset_midop;
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus_set(32'h30000, 1'b1, 8'hB0 + 8'(i)); tick;
    end
    bus_set(32'h10, 1'b0, 8'h00); tick;
    total++; if (tx_valid !== 1'b1) begin bad++; $display("FAIL pre_rst_tx_valid got=%b exp=1", tx_valid); end
    total++; if (bus_rdata !== 8'hA5) begin bad++; $display("FAIL pre_rst_rdata got=%h exp=a5", bus_rdata); end
    rst = 1'b1; tick; rst = 1'b0;
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL rst_tx_valid got=%b exp=0", tx_valid); end
    total++; if (halt !== 1'b0) begin bad++; $display("FAIL rst_halt got=%b exp=0", halt); end
    total++; if (cpu_rdy !== 1'b1) begin bad++; $display("FAIL rst_cpu_rdy got=%b exp=1", cpu_rdy); end
    total++; if (bus_rdata !== 8'h00) begin bad++; $display("FAIL rst_rdata got=%h exp=00", bus_rdata); end
    total++; if (rx_ready !== 1'b1) begin bad++; $display("FAIL rst_rx_ready got=%b exp=1", rx_ready); end
    tick;
    total++; if (bus_rdata !== 8'hA5) begin bad++; $display("FAIL ram_survives_rst got=%h exp=a5", bus_rdata); end
    bus_set(32'h30000, 1'b0, 8'h00); tick;
    total++; if (bus_rdata !== 8'h00) begin bad++; $display("FAIL rx_cleared_by_rst got=%h exp=00", bus_rdata); end
  endtask

  initial begin
    test_reset;
    test_write_read;
    test_back_to_back;
    test_tx_full;
    test_rx_pop;
    test_empty_and_halt;
    test_reset_midop;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
